// File: rtl/sort_pkg.sv
// Shared types for the sort frame controller: FSM state encoding, default element type and pad word.
package sort_pkg;

    localparam int ELEM_W = 8;

    typedef logic [ELEM_W-1:0] elem_t;

    // All-ones pads short frames so the pad sorts behind every real word.
    localparam elem_t PAD_VALUE = '1;

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        DRAIN
    } state_t;

endpackage

// File: rtl/sort_frame_ctrl_if.sv
// Serial input/output stream bundle between the producer/consumer pair and sort_frame_ctrl.
interface sort_frame_ctrl_if
    import sort_pkg::*;
#(
    parameter int WIDTH = ELEM_W
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/sort_lat_timer.sv
// Down-counter that asserts done SORT_LAT cycles after a start pulse, holding the sorter inputs stable.
module sort_lat_timer #(
    parameter int SORT_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);
    localparam int CW = $clog2(SORT_LAT + 1);

    logic [CW-1:0] cnt;
    logic          run;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            cnt <= CW'(SORT_LAT);
            run <= 1'b1;
        end else if (run) begin
            if (cnt == '0) begin
                run <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign done = run && (cnt == '0);
endmodule

// File: rtl/sort_frame_ctrl.sv
// Frame sequencer around an external combinational sorter: load, settle, capture, drain.
// Define SORT_FRAME_CTRL_CHECK_EN to add the sticky output-ordering checker on sort_err.
module sort_frame_ctrl
    import sort_pkg::*;
#(
    parameter int N        = 6,
    parameter int WIDTH    = ELEM_W,
    parameter int SORT_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    sort_frame_ctrl_if.slave    strm,
    output logic [WIDTH-1:0]    sort_operands [N],
    input  logic [WIDTH-1:0]    sort_result   [N],
    output logic                busy,
    output logic [CNT_W-1:0]    frames_done,
    output logic                sort_err
);
    localparam int IDX_W = $clog2(N);
    localparam int LEN_W = $clog2(N + 1);
    localparam logic [WIDTH-1:0] PAD = {WIDTH{PAD_VALUE[0]}};

    state_t           state;
    logic [WIDTH-1:0] opbuf [N];
    logic [WIDTH-1:0] obuf  [N];
    logic [IDX_W-1:0] wr_cnt;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] rd_nxt;
    logic [LEN_W-1:0] len;
    logic             in_acc;
    logic             out_acc;
    logic             closing;
    logic             timer_done;

    assign in_acc  = (state == LOAD) && strm.in_valid && strm.in_ready;
    assign closing = in_acc && (strm.in_last || (wr_cnt == IDX_W'(N - 1)));
    assign out_acc = (state == DRAIN) && strm.out_valid && strm.out_ready;
    assign rd_nxt  = rd_idx + 1'b1;

    assign sort_operands = opbuf;

    sort_lat_timer #(.SORT_LAT(SORT_LAT)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (closing),
        .done  (timer_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= LOAD;
            wr_cnt         <= '0;
            rd_idx         <= '0;
            len            <= '0;
            strm.in_ready  <= 1'b1;
            strm.out_valid <= 1'b0;
            strm.out_last  <= 1'b0;
            strm.out_data  <= '0;
            busy           <= 1'b0;
            frames_done    <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                opbuf[i] <= PAD;
                obuf[i]  <= PAD;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_acc) begin
                        for (int unsigned i = 0; i < N; i++) begin
                            if (i == 32'(wr_cnt)) begin
                                opbuf[i] <= strm.in_data;
                            end else if (closing && (i > 32'(wr_cnt))) begin
                                opbuf[i] <= PAD;
                            end
                        end
                        if (closing) begin
                            len           <= LEN_W'(wr_cnt) + 1'b1;
                            strm.in_ready <= 1'b0;
                            busy          <= 1'b1;
                            state         <= SORT;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                SORT: begin
                    // First output word is loaded straight from the sorter so out_data is valid with out_valid.
                    if (timer_done) begin
                        obuf           <= sort_result;
                        rd_idx         <= '0;
                        strm.out_valid <= 1'b1;
                        strm.out_data  <= sort_result[0];
                        strm.out_last  <= (len == LEN_W'(1));
                        state          <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_acc) begin
                        if (strm.out_last) begin
                            strm.out_valid <= 1'b0;
                            strm.out_last  <= 1'b0;
                            strm.out_data  <= '0;
                            frames_done    <= frames_done + 1'b1;
                            wr_cnt         <= '0;
                            rd_idx         <= '0;
                            strm.in_ready  <= 1'b1;
                            busy           <= 1'b0;
                            state          <= LOAD;
                            for (int unsigned i = 0; i < N; i++) begin
                                opbuf[i] <= PAD;
                            end
                        end else begin
                            rd_idx        <= rd_nxt;
                            strm.out_data <= obuf[rd_nxt];
                            strm.out_last <= (LEN_W'(rd_nxt) == (len - 1'b1));
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

`ifdef SORT_FRAME_CTRL_CHECK_EN
    logic [WIDTH-1:0] prev_beat;
    logic             err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_beat <= '0;
            err_q     <= 1'b0;
        end else if (out_acc) begin
            prev_beat <= strm.out_data;
            if ((rd_idx != '0) && (strm.out_data < prev_beat)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign sort_err = err_q;
`else
    assign sort_err = 1'b0;
`endif
endmodule
